// File: rtl/alarm_arm_controller.sv
// alarm_arm_controller
// Arming/disarming controller for the home alarm. Collects 3-digit keypad
// codes, tracks consecutive wrong codes while armed, runs the exit/entry/siren
// delays from one shared down-counter, and drives registered armed/siren/beep
// levels decoded from the next state so they change together with `state`.
module alarm_arm_controller #(
  parameter logic [11:0] ARM_CODE  = 12'h123,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned EXIT_CYC  = 100,
  parameter int unsigned ENTRY_CYC = 50,
  parameter int unsigned SIREN_CYC = 200,
  parameter int unsigned MAX_FAIL  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       door_open,
  input  logic       window_closed,
  input  logic       motion,
  output logic       armed,
  output logic       siren,
  output logic       beep,
  output logic [2:0] state
);

  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYC - 1);

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_EXIT_DLY  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY_DLY = 3'd3,
    ST_ALARM     = 3'd4
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [7:0]        hist_r;
  logic [1:0]        dcnt_r;
  logic [FAIL_W-1:0] fail_r;
  logic [FAIL_W-1:0] fail_inc_s;
  logic [FAIL_W-1:0] fail_next_s;
  logic              key_num_s;
  logic              key_clr_s;
  logic              third_s;
  logic              match_s;
  logic              mismatch_s;
  logic              guarded_s;
  logic              fail_limit_s;
  logic              sensor_s;
  logic              timeout_s;
  logic              load_s;
  logic [CNT_W-1:0]  load_val_s;

  // Keypad decode, code compare on the third digit, and fail-limit detection.
  always_comb begin
    key_num_s    = key_valid && (key_digit <= 4'd9);
    key_clr_s    = key_valid && (key_digit == 4'hF);
    third_s      = key_num_s && (dcnt_r == 2'd2);
    match_s      = third_s && ({hist_r, key_digit} == ARM_CODE);
    mismatch_s   = third_s && !match_s;
    guarded_s    = (state_r == ST_ARMED) || (state_r == ST_ENTRY_DLY);
    fail_inc_s   = fail_r + FAIL_W'(1);
    fail_limit_s = mismatch_s && guarded_s && (fail_inc_s == FAIL_W'(MAX_FAIL));
    sensor_s     = !window_closed || motion;
    timeout_s    = (cnt_r == {CNT_W{1'b0}});
  end

  // Next-state selection with priority match > fail-limit > sensors > timeout.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    load_val_s   = {CNT_W{1'b0}};
    case (state_r)
      ST_DISARMED: begin
        if (match_s) begin
          next_state_s = ST_EXIT_DLY;
          load_s       = 1'b1;
          load_val_s   = EXIT_LD;
        end else begin
          next_state_s = ST_DISARMED;
        end
      end
      ST_EXIT_DLY: begin
        if (match_s) begin
          next_state_s = ST_DISARMED;
        end else if (timeout_s) begin
          next_state_s = ST_ARMED;
        end else begin
          next_state_s = ST_EXIT_DLY;
        end
      end
      ST_ARMED: begin
        if (match_s) begin
          next_state_s = ST_DISARMED;
        end else if (fail_limit_s || sensor_s) begin
          next_state_s = ST_ALARM;
          load_s       = 1'b1;
          load_val_s   = SIREN_LD;
        end else if (door_open) begin
          next_state_s = ST_ENTRY_DLY;
          load_s       = 1'b1;
          load_val_s   = ENTRY_LD;
        end else begin
          next_state_s = ST_ARMED;
        end
      end
      ST_ENTRY_DLY: begin
        if (match_s) begin
          next_state_s = ST_DISARMED;
        end else if (fail_limit_s || sensor_s || timeout_s) begin
          next_state_s = ST_ALARM;
          load_s       = 1'b1;
          load_val_s   = SIREN_LD;
        end else begin
          next_state_s = ST_ENTRY_DLY;
        end
      end
      ST_ALARM: begin
        if (match_s) begin
          next_state_s = ST_DISARMED;
        end else if (timeout_s) begin
          next_state_s = ST_ARMED;
        end else begin
          next_state_s = ST_ALARM;
        end
      end
      default: begin
        next_state_s = ST_DISARMED;
      end
    endcase
  end

  // Fail-count update: cleared on match, on reaching the limit and on disarm.
  always_comb begin
    fail_next_s = fail_r;
    if (match_s || fail_limit_s || (next_state_s == ST_DISARMED)) begin
      fail_next_s = {FAIL_W{1'b0}};
    end else if (mismatch_s && guarded_s) begin
      fail_next_s = fail_inc_s;
    end else begin
      fail_next_s = fail_r;
    end
  end

  // State, counter, digit history and registered output decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_DISARMED;
      cnt_r   <= {CNT_W{1'b0}};
      hist_r  <= 8'h00;
      dcnt_r  <= 2'd0;
      fail_r  <= {FAIL_W{1'b0}};
      armed   <= 1'b0;
      siren   <= 1'b0;
      beep    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      fail_r  <= fail_next_s;
      armed   <= (next_state_s == ST_ARMED) || (next_state_s == ST_ENTRY_DLY) ||
                 (next_state_s == ST_ALARM);
      siren   <= (next_state_s == ST_ALARM);
      beep    <= (next_state_s == ST_EXIT_DLY) || (next_state_s == ST_ENTRY_DLY);
      if (load_s) begin
        cnt_r <= load_val_s;
      end else if (!timeout_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (key_num_s) begin
        hist_r <= {hist_r[3:0], key_digit};
        dcnt_r <= (dcnt_r == 2'd2) ? 2'd0 : dcnt_r + 2'd1;
      end else if (key_clr_s) begin
        hist_r <= hist_r;
        dcnt_r <= 2'd0;
      end else begin
        hist_r <= hist_r;
        dcnt_r <= dcnt_r;
      end
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_alarm_arm_controller.sv
// Directed bench for alarm_arm_controller: walks arming, entry delay, siren
// timeout, sensor alarms, wrong-code lockout and reset abort, checking the
// registered outputs against hand-computed values.
module tb_alarm_arm_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       door_open;
  logic       window_closed;
  logic       motion;
  logic       armed;
  logic       siren;
  logic       beep;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  alarm_arm_controller dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .door_open    (door_open),
    .window_closed(window_closed),
    .motion       (motion),
    .armed        (armed),
    .siren        (siren),
    .beep         (beep),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One keypad strobe lasting a single edge.
  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
    key_digit = 4'h0;
  endtask

  // Compare {state, armed, siren, beep} against the expected values.
  task automatic chk(input string tag, input logic [2:0] st, input logic a,
                     input logic s, input logic b);
    logic [5:0] got;
    logic [5:0] exp;
    got = {state, armed, siren, beep};
    exp = {st, a, s, b};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s state/armed/siren/beep got %0d/%b/%b/%b exp %0d/%b/%b/%b",
             tag, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_digit = 4'h0;
    door_open = 1'b0; window_closed = 1'b1; motion = 1'b0;
    ticks(2);
    chk("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // 1: arm with 1,2,3 and idle gaps; exit delay lasts exactly 100 cycles
    key(4'd1); tick();
    key(4'd2); tick();
    chk("two_digits_no_arm", 3'd0, 1'b0, 1'b0, 1'b0);
    key(4'd3);
    chk("exit_enter", 3'd1, 1'b0, 1'b0, 1'b1);
    ticks(99);
    chk("exit_99", 3'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("exit_done", 3'd2, 1'b1, 1'b0, 1'b0);

    // 2: door -> entry delay 50 -> alarm 200 -> re-arm
    door_open = 1'b1; tick(); door_open = 1'b0;
    chk("entry_enter", 3'd3, 1'b1, 1'b0, 1'b1);
    ticks(49);
    chk("entry_49", 3'd3, 1'b1, 1'b0, 1'b1);
    tick();
    chk("entry_timeout", 3'd4, 1'b1, 1'b1, 1'b0);
    ticks(199);
    chk("siren_199", 3'd4, 1'b1, 1'b1, 1'b0);
    tick();
    chk("siren_timeout", 3'd2, 1'b1, 1'b0, 1'b0);

    // 3: motion -> alarm immediately; code disarms
    motion = 1'b1; tick(); motion = 1'b0;
    chk("motion_alarm", 3'd4, 1'b1, 1'b1, 1'b0);
    key(4'd1); key(4'd2); key(4'd3);
    chk("alarm_disarm", 3'd0, 1'b0, 1'b0, 1'b0);

    // re-arm
    key(4'd1); key(4'd2); key(4'd3);
    ticks(100);
    chk("rearm", 3'd2, 1'b1, 1'b0, 1'b0);

    // 4: three wrong codes -> alarm; F discards a partial code
    key(4'd9); key(4'd9); key(4'd9);
    chk("wrong1", 3'd2, 1'b1, 1'b0, 1'b0);
    key(4'd9); key(4'd9); key(4'd9);
    chk("wrong2", 3'd2, 1'b1, 1'b0, 1'b0);
    key(4'd9); key(4'd9); key(4'd9);
    chk("wrong3_alarm", 3'd4, 1'b1, 1'b1, 1'b0);
    key(4'd1); key(4'hF); key(4'hB); key(4'd1); key(4'd2);
    chk("clear_then_partial", 3'd4, 1'b1, 1'b1, 1'b0);
    key(4'd3);
    chk("clear_then_match", 3'd0, 1'b0, 1'b0, 1'b0);

    // 5: sensor faults ignored while disarmed and in exit delay
    window_closed = 1'b0; motion = 1'b1;
    tick();
    chk("disarmed_ignores", 3'd0, 1'b0, 1'b0, 1'b0);
    key(4'd1); key(4'd2); key(4'd3);
    chk("exit_fault", 3'd1, 1'b0, 1'b0, 1'b1);
    ticks(99);
    chk("exit_fault_99", 3'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("exit_fault_armed", 3'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fault_persist_alarm", 3'd4, 1'b1, 1'b1, 1'b0);
    window_closed = 1'b1; motion = 1'b0;
    key(4'd1); key(4'd2); key(4'd3);
    chk("fault_disarm", 3'd0, 1'b0, 1'b0, 1'b0);

    // 6: match on the same edge as the entry-delay timeout wins
    key(4'd1); key(4'd2); key(4'd3);
    ticks(100);
    door_open = 1'b1; tick(); door_open = 1'b0;
    chk("entry2", 3'd3, 1'b1, 1'b0, 1'b1);
    ticks(47);
    key(4'd1); key(4'd2);
    chk("entry2_before_edge", 3'd3, 1'b1, 1'b0, 1'b1);
    key(4'd3);
    chk("match_beats_timeout", 3'd0, 1'b0, 1'b0, 1'b0);

    // reset during alarm aborts and clears the partial digit count
    key(4'd1); key(4'd2); key(4'd3);
    ticks(100);
    motion = 1'b1; tick(); motion = 1'b0;
    chk("alarm_before_rst", 3'd4, 1'b1, 1'b1, 1'b0);
    key(4'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_in_alarm", 3'd0, 1'b0, 1'b0, 1'b0);
    key(4'd2); key(4'd3);
    chk("rst_clears_digits", 3'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_arm_controller.md
Name: alarm_arm_controller

Overview:
- Sequential arming/disarming controller for the home alarm.
- Accepts keypad digits and sensor levels.
- Produces the registered `armed` level, which is the enable consumed by the combinational alarm logic, plus siren and status outputs.
- Implements exit delay, entry delay, siren timeout and wrong-code lockout.

Parameters:
- ARM_CODE, 12'h123: 3-digit BCD code; first digit in [11:8].
- CNT_W, 16: width of the shared delay counter.
- EXIT_CYC, 100: cycles spent in EXIT_DLY; must be ≥1.
- ENTRY_CYC, 50: cycles spent in ENTRY_DLY; must be ≥1.
- SIREN_CYC, 200: cycles spent in ALARM before auto re-arm; must be ≥1.
- MAX_FAIL, 3: consecutive wrong codes that force ALARM.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- key_valid, input, 1: one-cycle strobe; key_digit is valid.
- key_digit, input, 4: 0–9 digit, 4'hF clear; 4'hA–4'hE ignored.
- door_open, input, 1: entry door contact, 1 = open.
- window_closed, input, 1: window contact, 1 = closed.
- motion, input, 1: PIR level, 1 = motion.
- armed, output, 1: 1 in ARMED, ENTRY_DLY and ALARM.
- siren, output, 1: 1 in ALARM only.
- beep, output, 1: 1 in EXIT_DLY and ENTRY_DLY.
- state, output, 3: DISARMED=0, EXIT_DLY=1, ARMED=2, ENTRY_DLY=3, ALARM=4.

Behaviour:
- Reset: rst sampled high on a clk edge gives:
  - state=DISARMED; armed=siren=beep=0.
  - Digit buffer and digit count cleared; fail count=0; counter=0.
  - Reset mid-delay or mid-alarm aborts immediately.
- All outputs are registered and decoded from the state register. They change on the edge that updates state, so there is no extra latency.
- Code entry (all states):
  - Each key_valid with digit 0–9 shifts into a 2-digit history and increments digit count (0..2).
  - On the 3rd digit, compare {history, key_digit} against ARM_CODE on that same edge. This produces a match or a mismatch event.
  - Digit count returns to 0 after the compare.
  - 4'hF clears the digit count; 4'hA–4'hE change nothing.
- Fail count:
  - Increments on each mismatch event while in ARMED or ENTRY_DLY; mismatches in other states leave it unchanged.
  - Cleared on any match and on entry to DISARMED.
  - When the increment reaches MAX_FAIL, the FSM enters ALARM and the fail count is cleared.
- Counter:
  - Loaded with (N-1) on entry to each timed state.
  - Decrements each cycle; the timeout event occurs at counter==0.
  - The state is therefore held exactly N cycles.
- Transitions. Priority, high to low: rst, match, fail-limit, sensors, timeout.
  - DISARMED: match→EXIT_DLY (load EXIT_CYC-1). Sensors ignored.
  - EXIT_DLY: match→DISARMED; timeout→ARMED. Sensors ignored.
  - ARMED:
    - match→DISARMED.
    - fail-limit→ALARM.
    - (~window_closed | motion)→ALARM (load SIREN_CYC-1).
    - door_open→ENTRY_DLY (load ENTRY_CYC-1).
  - ENTRY_DLY: match→DISARMED; fail-limit→ALARM; (~window_closed | motion)→ALARM; timeout→ALARM.
  - ALARM:
    - match→DISARMED.
    - timeout→ARMED, with siren dropping on that edge.
    - Sensors are re-evaluated in ARMED on the next cycle, so a persistent fault re-triggers ALARM one cycle later.
- Simultaneous events:
  - Match and sensor on the same edge: match wins.
  - door_open and window fault on the same edge in ARMED: goes to ALARM.
- Counter width: parameters exceeding 2^CNT_W are a configuration error; no saturation logic is required.

Test Plan:
1. Reset, then key 1,2,3 (one strobe each, idle cycles between) → state=1 and beep=1 on the 3rd-digit edge. After exactly 100 cycles: state=2, armed=1, beep=0.
2. ARMED, door_open=1 for one cycle → state=3, beep=1. No code entered; after 50 cycles: state=4, siren=1. After 200 more cycles: state=2, siren=0.
3. ARMED, motion=1 → state=4 on the same edge. Key 1,2,3 → state=0, armed=siren=0 on the 3rd-digit edge.
4. ARMED, key 9,9,9 three times → state stays 2 after the 1st and 2nd wrong codes; state=4 on the 3rd. Then key 1,F,1,2,3 → the F discards the first 1, the following 1,2,3 matches, and state=0.
5. EXIT_DLY with window_closed=0 and motion=1 → ignored, reaches ARMED after 100 cycles. ALARM follows on the next edge because the fault persists.
6. ENTRY_DLY: 3rd code digit and timeout (counter==0) on the same edge → state=0. Assert rst during ALARM → state=0 and all outputs 0 on the next edge.
